// File: rtl/pwm_pkg.sv
// Shared constants, output-mode encoding and compare helper for the PWM controller slice.
package pwm_pkg;

  localparam int unsigned PWM_CNT_W       = 8;
  localparam int unsigned NUM_OUT         = 16;
  localparam int unsigned CLK_DIV_DEFAULT = 13;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;

  typedef enum logic [1:0] {
    OUT_LOW  = 2'd0,
    OUT_HIGH = 2'd1,
    OUT_PWM  = 2'd2
  } out_mode_e;

  // PWM select only matters when the output itself is enabled.
  function automatic out_mode_e out_mode(input logic en_out, input logic en_pwm);
    if (!en_out)     return OUT_LOW;
    else if (!en_pwm) return OUT_HIGH;
    else             return OUT_PWM;
  endfunction

  // Full-scale duty is forced high so the last count of the period does not dip low.
  function automatic logic pwm_compare(input logic [PWM_CNT_W-1:0] cnt,
                                       input logic [PWM_CNT_W-1:0] duty);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: free-running prescaler, 8-bit period counter and registered period_start pulse.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [PWM_CNT_W-1:0] pwm_cnt,
  output logic                 boundary,
  output logic                 period_start
);

  localparam int unsigned     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]     prescaler_q, prescaler_d;
  logic [PWM_CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                 period_start_q, period_start_d;
  logic                 tick;

  // Next-state for prescaler and period counter; boundary is the last step of a period.
  always_comb begin
    tick           = (prescaler_q == DIV_LAST);
    prescaler_d    = tick ? '0 : prescaler_q + 1'b1;
    pwm_cnt_d      = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    boundary       = tick && (pwm_cnt_q == '1);
    period_start_d = boundary;
  end

  // Timebase registers; reset aborts the current period.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_q    <= '0;
      pwm_cnt_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      prescaler_q    <= prescaler_d;
      pwm_cnt_q      <= pwm_cnt_d;
      period_start_q <= period_start_d;
    end
  end

  assign pwm_cnt      = pwm_cnt_q;
  assign period_start = period_start_q;

endmodule

// File: rtl/pwm_controller.sv
// PWM controller: duty selection, shared compare and per-output mux with registered outputs.
// Optional macro PWM_SHADOW_EN: duty is shadowed and only reloaded at period boundaries.
module pwm_controller
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           en_reg_out_7_0,
  input  logic [7:0]           en_reg_out_15_8,
  input  logic [7:0]           en_reg_pwm_7_0,
  input  logic [7:0]           en_reg_pwm_15_8,
  input  logic [7:0]           pwm_duty_cycle,
  output logic [NUM_OUT-1:0]   out,
  output logic                 period_start
);

  logic [PWM_CNT_W-1:0] pwm_cnt;
  logic                 boundary;
  logic [PWM_CNT_W-1:0] duty_active;
  logic                 pwm_raw;
  logic [NUM_OUT-1:0]   en_out, en_pwm;
  logic [NUM_OUT-1:0]   out_q, out_d;

  pwm_timebase #(
    .CLK_DIV (CLK_DIV)
  ) u_timebase (
    .clk          (clk),
    .rst          (rst),
    .pwm_cnt      (pwm_cnt),
    .boundary     (boundary),
    .period_start (period_start)
  );

`ifdef PWM_SHADOW_EN
  logic [PWM_CNT_W-1:0] duty_q, duty_d;

  // Capture the requested duty only on the boundary edge so each period is whole.
  always_comb begin
    duty_d = boundary ? pwm_duty_cycle : duty_q;
  end

  // Shadow duty register; the first period after reset runs at duty 0.
  always_ff @(posedge clk) begin
    if (rst) duty_q <= '0;
    else     duty_q <= duty_d;
  end

  assign duty_active = duty_q;
`else
  logic unused_boundary;

  // Duty follows the input directly; mid-period changes may produce runt pulses.
  always_comb begin
    duty_active     = pwm_duty_cycle;
    unused_boundary = boundary;
  end
`endif

  // Shared compare and per-output source selection.
  always_comb begin
    en_out  = {en_reg_out_15_8, en_reg_out_7_0};
    en_pwm  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    pwm_raw = pwm_compare(pwm_cnt, duty_active);
    out_d   = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      unique case (out_mode(en_out[i], en_pwm[i]))
        OUT_LOW:  out_d[i] = 1'b0;
        OUT_HIGH: out_d[i] = 1'b1;
        OUT_PWM:  out_d[i] = pwm_raw;
        default:  out_d[i] = 1'b0;
      endcase
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign out = out_q;

endmodule

// File: tb/tb_pwm_controller.sv
// Self-checking bench for pwm_controller (CLK_DIV = 13); honours PWM_SHADOW_EN.
module tb_pwm_controller;

  localparam int DIV    = 13;
  localparam int PERIOD = 256 * DIV;
`ifdef PWM_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] en_o = '0;
  logic [15:0] en_p = '0;
  logic [7:0]  duty = '0;
  logic [15:0] out;
  logic        period_start;

  pwm_controller #(.CLK_DIV(DIV)) dut (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_o[7:0]),
    .en_reg_out_15_8 (en_o[15:8]),
    .en_reg_pwm_7_0  (en_p[7:0]),
    .en_reg_pwm_15_8 (en_p[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (period_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] out;
    logic        ps;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   mc = 0;            // cycles since reset release (model state index)
  logic [7:0] m_sh = '0;   // model shadow duty
  logic obs_ps = 1'b0;
  int   hi_acc = 0;        // cycles with out[0] high
  int   any_hi_acc = 0;    // cycles with any of out[7:0] high
  int   any_lo_acc = 0;    // cycles with any of out[7:0] low

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: predict the post-edge outputs, advance, then compare.
  task automatic step();
    exp_t e;
    logic [7:0] da;
    logic raw;
    logic bnd;
    int cnt;
    bnd = 1'b0;
    if (rst) begin
      e = '0;
    end else begin
      cnt   = (mc / DIV) % 256;
      da    = SHADOW ? m_sh : duty;
      raw   = (da == 8'hFF) || (cnt < int'(da));
      e.out = en_o & (~en_p | {16{raw}});
      bnd   = (mc % PERIOD) == (PERIOD - 1);
      e.ps  = bnd;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (rst) begin
      mc   = 0;
      m_sh = '0;
    end else begin
      if (SHADOW && bnd) m_sh = duty;
      mc++;
    end
    e = sb_q.pop_front();
    check_val("out", 32'(out), 32'(e.out));
    check_val("period_start", 32'(period_start), 32'(e.ps));
    obs_ps = period_start;
    hi_acc += int'(out[0]);
    if (out[7:0] != 8'h00) any_hi_acc++;
    if (out[7:0] != 8'hFF) any_lo_acc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_ps(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!obs_ps && n < budget);
    check_val("ps_seen", 32'(obs_ps), 32'd1);
  endtask

  int n;
  int lows;

  initial begin
    // 1. reset and idle
    rst = 1'b1;
    run(5);
    check_val("reset_out", 32'(out), 32'd0);
    rst = 1'b0;
    wait_ps(PERIOD + 100, n);
    check_val("first_ps_latency", 32'(n), 32'(PERIOD));

    // 2. static high
    en_o = 16'hFFFF;
    en_p = 16'h0000;
    step();
    check_val("static_high", 32'(out), 32'h0000FFFF);
    lows = 0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      step();
      if (out !== 16'hFFFF) lows++;
    end
    check_val("static_const", 32'(lows), 32'd0);

    // 3. 50% duty
    en_o = 16'h00FF;
    en_p = 16'h00FF;
    duty = 8'h80;
    wait_ps(PERIOD + 100, n);
    hi_acc = 0;
    run(PERIOD);
    check_val("duty50_high", 32'(hi_acc), 32'd1664);
    check_val("upper_off", 32'(out[15:8]), 32'd0);
    hi_acc = 0;
    run(PERIOD);
    check_val("duty50_high_2", 32'(hi_acc), 32'd1664);

    // 4. extremes
    duty = 8'h00;
    wait_ps(PERIOD + 100, n);
    any_hi_acc = 0;
    run(3 * PERIOD);
    check_val("duty0_never_high", 32'(any_hi_acc), 32'd0);
    duty = 8'hFF;
    wait_ps(PERIOD + 100, n);
    any_lo_acc = 0;
    run(3 * PERIOD);
    check_val("dutyff_never_low", 32'(any_lo_acc), 32'd0);

    // 5. mid-period duty update at pwm_cnt == 0x20
    duty = 8'h40;
    wait_ps(PERIOD + 100, n);
    hi_acc = 0;
    run(32'h20 * DIV);
    duty = 8'hC0;
    run(PERIOD - 32'h20 * DIV);
    check_val("midupd_cur_high", 32'(hi_acc), SHADOW ? 32'd832 : 32'd2496);
    hi_acc = 0;
    run(PERIOD);
    check_val("midupd_next_high", 32'(hi_acc), 32'd2496);

    // 6. reset mid-period at pwm_cnt == 0x90
    run(32'h90 * DIV);
    check_val("active_before_rst", 32'(out[0]), 32'd1);
    rst = 1'b1;
    step();
    check_val("rst_out", 32'(out), 32'd0);
    run(2);
    rst = 1'b0;
    wait_ps(PERIOD + 100, n);
    check_val("ps_after_rst", 32'(n), 32'(PERIOD));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
